// File: rtl/sdrc_arb_pkg.sv
// Shared definitions for the two-port SDRAM application arbiter.
// State encoding, port count and grant helpers.
package sdrc_arb_pkg;

  localparam int ARB_PORTS = 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CMD     = 2'd1;
  localparam logic [1:0] ST_WR_DATA = 2'd2;
  localparam logic [1:0] ST_RD_DATA = 2'd3;

  typedef logic [ARB_PORTS-1:0] grant_t;

  function automatic grant_t port_onehot(input logic port);
    return port ? grant_t'(2'b10) : grant_t'(2'b01);
  endfunction

endpackage

// File: rtl/sdrc_rr_pick.sv
// Combinational 2-way round-robin picker.
// pri = 0 favours port 0, pri = 1 favours port 1.
module sdrc_rr_pick
  import sdrc_arb_pkg::*;
(
  input  grant_t req,
  input  logic   pri,
  output grant_t win
);

  always_comb begin
    win = '0;
    unique case (1'b1)
      (req[0] && (!req[1] || !pri)): win = port_onehot(1'b0);
      (req[1] && (!req[0] ||  pri)): win = port_onehot(1'b1);
      default:                       win = '0;
    endcase
  end

endmodule

// File: rtl/sdrc_app_arbiter.sv
// Round-robin owner of the sdrc_top application interface.
// Holds the interface for one full burst: command plus all data beats.
module sdrc_app_arbiter
  import sdrc_arb_pkg::*;
#(
  parameter int APP_AW = 26,
  parameter int dw     = 64,
  parameter int bl     = 9
) (
  input  logic              sdram_clk,
  input  logic              sdram_reset,
  input  logic              sdr_init_done,

  input  logic              p0_req,
  input  logic [APP_AW-1:0] p0_req_addr,
  input  logic [bl-1:0]     p0_req_len,
  input  logic              p0_req_wr_n,
  input  logic              p0_req_wrap,
  output logic              p0_req_ack,
  input  logic [dw-1:0]     p0_wr_data,
  input  logic [dw/8-1:0]   p0_wr_en_n,
  output logic              p0_wr_next_req,
  output logic              p0_last_wr,
  output logic              p0_rd_valid,
  output logic              p0_last_rd,
  output logic [dw-1:0]     p0_rd_data,

  input  logic              p1_req,
  input  logic [APP_AW-1:0] p1_req_addr,
  input  logic [bl-1:0]     p1_req_len,
  input  logic              p1_req_wr_n,
  input  logic              p1_req_wrap,
  output logic              p1_req_ack,
  input  logic [dw-1:0]     p1_wr_data,
  input  logic [dw/8-1:0]   p1_wr_en_n,
  output logic              p1_wr_next_req,
  output logic              p1_last_wr,
  output logic              p1_rd_valid,
  output logic              p1_last_rd,
  output logic [dw-1:0]     p1_rd_data,

  output logic              app_req,
  output logic [APP_AW-1:0] app_req_addr,
  output logic [bl-1:0]     app_req_len,
  output logic              app_req_wr_n,
  output logic              app_req_wrap,
  output logic [dw-1:0]     app_wr_data,
  output logic [dw/8-1:0]   app_wr_en_n,
  input  logic              app_req_ack,
  input  logic              app_wr_next_req,
  input  logic              app_last_wr,
  input  logic              app_rd_valid,
  input  logic              app_last_rd,
  input  logic [dw-1:0]     app_rd_data,

  output logic [1:0]        arb_grant,
  output logic              arb_busy
);

  logic [1:0]        state;
  grant_t            grant;
  logic              rr_pri;
  grant_t            win;

  logic              in_cmd;
  logic              in_wr;
  logic              in_rd;
  logic              rd_end;

  logic [APP_AW-1:0] sel_addr;
  logic [bl-1:0]     sel_len;
  logic              sel_wr_n;
  logic              sel_wrap;
  logic [dw-1:0]     sel_wdata;
  logic [dw/8-1:0]   sel_en_n;

  sdrc_rr_pick u_pick (
    .req (grant_t'({p1_req, p0_req})),
    .pri (rr_pri),
    .win (win)
  );

  assign in_cmd = (state == ST_CMD);
  assign in_wr  = (state == ST_WR_DATA);
  assign in_rd  = (state == ST_RD_DATA);
  assign rd_end = app_rd_valid & app_last_rd;

  // rr_pri tracks the port that did NOT win last, so win[0] is ~N.
  always_ff @(posedge sdram_clk) begin
    if (sdram_reset) begin
      state  <= ST_IDLE;
      grant  <= '0;
      rr_pri <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (sdr_init_done && (|win)) begin
            grant  <= win;
            rr_pri <= win[0];
            state  <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (app_req_ack) begin
            state <= sel_wr_n ? ST_RD_DATA : ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (app_last_wr) begin
            grant <= '0;
            state <= ST_IDLE;
          end
        end
        ST_RD_DATA: begin
          if (rd_end) begin
            grant <= '0;
            state <= ST_IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    sel_addr  = p0_req_addr;
    sel_len   = p0_req_len;
    sel_wr_n  = p0_req_wr_n;
    sel_wrap  = p0_req_wrap;
    sel_wdata = p0_wr_data;
    sel_en_n  = p0_wr_en_n;
    if (grant[1]) begin
      sel_addr  = p1_req_addr;
      sel_len   = p1_req_len;
      sel_wr_n  = p1_req_wr_n;
      sel_wrap  = p1_req_wrap;
      sel_wdata = p1_wr_data;
      sel_en_n  = p1_wr_en_n;
    end
  end

  assign app_req      = in_cmd;
  assign app_req_addr = in_cmd ? sel_addr : '0;
  assign app_req_len  = in_cmd ? sel_len  : '0;
  assign app_req_wr_n = in_cmd & sel_wr_n;
  assign app_req_wrap = in_cmd & sel_wrap;

  assign app_wr_data  = in_wr ? sel_wdata : '0;
  assign app_wr_en_n  = in_wr ? sel_en_n  : '1;

  assign p0_req_ack     = in_cmd & app_req_ack & grant[0];
  assign p1_req_ack     = in_cmd & app_req_ack & grant[1];

  assign p0_wr_next_req = in_wr & app_wr_next_req & grant[0];
  assign p1_wr_next_req = in_wr & app_wr_next_req & grant[1];
  assign p0_last_wr     = in_wr & app_last_wr & grant[0];
  assign p1_last_wr     = in_wr & app_last_wr & grant[1];

  assign p0_rd_valid    = in_rd & app_rd_valid & grant[0];
  assign p1_rd_valid    = in_rd & app_rd_valid & grant[1];
  assign p0_last_rd     = in_rd & rd_end & grant[0];
  assign p1_last_rd     = in_rd & rd_end & grant[1];

  assign p0_rd_data     = app_rd_data;
  assign p1_rd_data     = app_rd_data;

  assign arb_grant      = grant;
  assign arb_busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_sdrc_app_arbiter.sv
// Scoreboard bench for sdrc_app_arbiter with a small sdrc_top model.
// Expected bursts are queued at issue time; a monitor checks routing.
module tb_sdrc_app_arbiter;

  localparam int AW = 26;
  localparam int DW = 64;
  localparam int BL = 9;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_done = 1'b0;

  logic          p0_req = 1'b0, p1_req = 1'b0;
  logic [AW-1:0] p0_req_addr = '0, p1_req_addr = '0;
  logic [BL-1:0] p0_req_len = '0, p1_req_len = '0;
  logic          p0_req_wr_n = 1'b1, p1_req_wr_n = 1'b1;
  logic          p0_req_wrap = 1'b0, p1_req_wrap = 1'b0;
  logic [DW-1:0] p0_wr_data = 64'h0123_4567_89AB_CDEF;
  logic [DW-1:0] p1_wr_data = 64'hFEDC_BA98_7654_3210;
  logic [BW-1:0] p0_wr_en_n = 8'h00;
  logic [BW-1:0] p1_wr_en_n = 8'hF0;
  logic          p0_req_ack, p1_req_ack;
  logic          p0_wr_next_req, p1_wr_next_req;
  logic          p0_last_wr, p1_last_wr;
  logic          p0_rd_valid, p1_rd_valid;
  logic          p0_last_rd, p1_last_rd;
  logic [DW-1:0] p0_rd_data, p1_rd_data;

  logic          app_req;
  logic [AW-1:0] app_req_addr;
  logic [BL-1:0] app_req_len;
  logic          app_req_wr_n, app_req_wrap;
  logic [DW-1:0] app_wr_data;
  logic [BW-1:0] app_wr_en_n;
  logic          app_req_ack = 1'b0;
  logic          app_wr_next_req = 1'b0;
  logic          app_last_wr = 1'b0;
  logic          app_rd_valid = 1'b0;
  logic          app_last_rd = 1'b0;
  logic [DW-1:0] app_rd_data = '0;
  logic [1:0]    arb_grant;
  logic          arb_busy;

  sdrc_app_arbiter #(.APP_AW(AW), .dw(DW), .bl(BL)) dut (
    .sdram_clk(clk), .sdram_reset(rst), .sdr_init_done(init_done),
    .p0_req(p0_req), .p0_req_addr(p0_req_addr), .p0_req_len(p0_req_len),
    .p0_req_wr_n(p0_req_wr_n), .p0_req_wrap(p0_req_wrap),
    .p0_req_ack(p0_req_ack), .p0_wr_data(p0_wr_data),
    .p0_wr_en_n(p0_wr_en_n), .p0_wr_next_req(p0_wr_next_req),
    .p0_last_wr(p0_last_wr), .p0_rd_valid(p0_rd_valid),
    .p0_last_rd(p0_last_rd), .p0_rd_data(p0_rd_data),
    .p1_req(p1_req), .p1_req_addr(p1_req_addr), .p1_req_len(p1_req_len),
    .p1_req_wr_n(p1_req_wr_n), .p1_req_wrap(p1_req_wrap),
    .p1_req_ack(p1_req_ack), .p1_wr_data(p1_wr_data),
    .p1_wr_en_n(p1_wr_en_n), .p1_wr_next_req(p1_wr_next_req),
    .p1_last_wr(p1_last_wr), .p1_rd_valid(p1_rd_valid),
    .p1_last_rd(p1_last_rd), .p1_rd_data(p1_rd_data),
    .app_req(app_req), .app_req_addr(app_req_addr),
    .app_req_len(app_req_len), .app_req_wr_n(app_req_wr_n),
    .app_req_wrap(app_req_wrap), .app_wr_data(app_wr_data),
    .app_wr_en_n(app_wr_en_n), .app_req_ack(app_req_ack),
    .app_wr_next_req(app_wr_next_req), .app_last_wr(app_last_wr),
    .app_rd_valid(app_rd_valid), .app_last_rd(app_last_rd),
    .app_rd_data(app_rd_data),
    .arb_grant(arb_grant), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          port;
    logic [AW-1:0] addr;
    logic [BL-1:0] len;
    logic          wr_n;
    logic [DW-1:0] wdata;
    logic [BW-1:0] en_n;
  } item_t;

  item_t exp_q[$];

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Controller model knobs
  int ack_dly = 0;
  bit gaps = 1'b0;

  int            c_st = 0, c_cnt = 0, c_beat = 0, c_gap = 0;
  logic [BL-1:0] c_len;
  logic          c_wr_n;
  logic [AW-1:0] c_addr;

  initial begin : ctl
    forever begin
      @(posedge clk);
      #1;
      app_req_ack = 0; app_wr_next_req = 0; app_last_wr = 0;
      app_rd_valid = 0; app_last_rd = 0; app_rd_data = '0;
      if (rst) begin
        c_st = 0;
        continue;
      end
      if (c_st == 0 && app_req) begin
        c_st = 1;
        c_cnt = ack_dly;
      end
      if (c_st == 1) begin
        if (c_cnt == 0) begin
          app_req_ack = 1;
          c_len = app_req_len; c_wr_n = app_req_wr_n; c_addr = app_req_addr;
          c_beat = 0; c_gap = 0; c_st = 2;
        end else c_cnt--;
      end else if (c_st == 2) begin
        if (!(gaps && (c_gap % 3) == 1)) begin
          if (!c_wr_n) begin
            app_wr_next_req = 1;
            app_last_wr = (c_beat == int'(c_len) - 1);
          end else begin
            app_rd_valid = 1;
            app_rd_data = {6'd0, c_addr, 24'd0, 8'(c_beat)};
            app_last_rd = (c_beat == int'(c_len) - 1);
          end
          c_beat++;
          if (c_beat == int'(c_len)) c_st = 0;
        end
        c_gap++;
      end
    end
  end

  // Monitor / scoreboard
  item_t      cur;
  bit         m_active = 0, m_idle = 0;
  int         m_beats = 0;
  logic [1:0] g;

  initial begin : mon
    forever begin
      @(negedge clk);
      if (rst) begin
        m_active = 0; m_idle = 0;
        continue;
      end
      if (m_idle) begin
        check("idle_grant", 64'(arb_grant), 0);
        check("idle_busy", 64'(arb_busy), 0);
        m_idle = 0;
      end
      if (app_req) begin
        if (!m_active) begin
          if (exp_q.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL cmd_unexpected: got addr %0h expected no command", app_req_addr);
          end else begin
            cur = exp_q.pop_front();
            m_active = 1; m_beats = 0;
            g = cur.port ? 2'b10 : 2'b01;
            check("cmd_grant", 64'(arb_grant), 64'(g));
            check("cmd_addr", 64'(app_req_addr), 64'(cur.addr));
            check("cmd_len", 64'(app_req_len), 64'(cur.len));
            check("cmd_wr_n", 64'(app_req_wr_n), 64'(cur.wr_n));
          end
        end else begin
          check("cmd_addr_stable", 64'(app_req_addr), 64'(cur.addr));
          check("cmd_len_stable", 64'(app_req_len), 64'(cur.len));
        end
        check("cmd_wr_en_n", 64'(app_wr_en_n), 64'hFF);
        if (app_req_ack)
          check("req_ack_route", 64'({p1_req_ack, p0_req_ack}), 64'(g));
        else
          check("req_ack_quiet", 64'({p1_req_ack, p0_req_ack}), 0);
      end else if (m_active) begin
        if (!cur.wr_n) begin
          if (app_wr_next_req) begin
            check("wr_next_route",
                  64'({p1_wr_next_req, p0_wr_next_req}), 64'(g));
            check("wr_data", app_wr_data, cur.wdata);
            check("wr_en_n", 64'(app_wr_en_n), 64'(cur.en_n));
            m_beats++;
          end
          if (app_last_wr) begin
            check("last_wr_route", 64'({p1_last_wr, p0_last_wr}), 64'(g));
            check("wr_beats", 64'(m_beats), 64'(cur.len));
            m_active = 0; m_idle = 1;
          end
        end else begin
          if (app_rd_valid) begin
            check("rd_valid_route", 64'({p1_rd_valid, p0_rd_valid}), 64'(g));
            check("rd_data", cur.port ? p1_rd_data : p0_rd_data,
                  {6'd0, cur.addr, 24'd0, 8'(m_beats)});
            m_beats++;
            if (app_last_rd) begin
              check("last_rd_route", 64'({p1_last_rd, p0_last_rd}), 64'(g));
              check("rd_beats", 64'(m_beats), 64'(cur.len));
              m_active = 0; m_idle = 1;
            end else begin
              check("last_rd_quiet", 64'({p1_last_rd, p0_last_rd}), 0);
            end
          end else begin
            check("rd_gap_quiet", 64'({p1_rd_valid, p0_rd_valid}), 0);
          end
        end
      end
    end
  end

  // Stimulus
  int pend0 = 0, pend1 = 0;

  task automatic step();
    @(negedge clk);
    #1;
    if (p0_req_ack) pend0--;
    if (p1_req_ack) pend1--;
    p0_req = (pend0 > 0);
    p1_req = (pend1 > 0);
  endtask

  task automatic push(input logic port);
    item_t it;
    it.port  = port;
    it.addr  = port ? p1_req_addr : p0_req_addr;
    it.len   = port ? p1_req_len  : p0_req_len;
    it.wr_n  = port ? p1_req_wr_n : p0_req_wr_n;
    it.wdata = port ? p1_wr_data  : p0_wr_data;
    it.en_n  = port ? p1_wr_en_n  : p0_wr_en_n;
    exp_q.push_back(it);
  endtask

  task automatic run_done(input string name, input int max);
    for (int i = 0; i < max; i++) begin
      step();
      if (exp_q.size() == 0 && !arb_busy && pend0 == 0 && pend1 == 0)
        return;
    end
    nchk++; nerr++;
    $display("FAIL %s_timeout: got busy=%0d queued=%0d expected idle",
             name, arb_busy, exp_q.size());
  endtask

  initial begin : wdog
    #400000;
    $display("FAIL watchdog: got no finish expected finish before 400us");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int   n;
    logic seen;

    // T1: init gating, then p0 write len 4
    p0_req_addr = 26'h012_3450; p0_req_len = 9'd4; p0_req_wr_n = 1'b0;
    push(1'b0); pend0 = 1; p0_req = 1;
    for (int i = 0; i < 3; i++) step();
    check("rst_grant", 64'(arb_grant), 0);
    check("rst_busy", 64'(arb_busy), 0);
    check("rst_app_req", 64'(app_req), 0);
    check("rst_wr_en_n", 64'(app_wr_en_n), 64'hFF);
    check("rst_acks", 64'({p1_req_ack, p0_req_ack}), 0);
    rst = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      seen = seen | app_req;
    end
    check("no_grant_before_init", 64'(seen), 0);
    init_done = 1;
    step();
    check("grant_latency_app_req", 64'(app_req), 1);
    check("grant_latency_addr", 64'(app_req_addr), 64'h012_3450);
    run_done("t1", 100);

    // T5: ack delayed 5 cycles on a p0 read
    ack_dly = 5;
    p0_req_addr = 26'h0AB_CDE0; p0_req_len = 9'd2; p0_req_wr_n = 1'b1;
    push(1'b0); pend0 = 1; p0_req = 1;
    run_done("t5", 100);
    ack_dly = 0;

    // T4: p1 read len 8 with valid gaps
    gaps = 1;
    p1_req_addr = 26'h155_5550; p1_req_len = 9'd8; p1_req_wr_n = 1'b1;
    push(1'b1); pend1 = 1; p1_req = 1;
    run_done("t4", 200);
    gaps = 0;

    // T6: reset during a p0 write burst
    p0_req_addr = 26'h2A0_0000; p0_req_len = 9'd8; p0_req_wr_n = 1'b0;
    push(1'b0); pend0 = 1; p0_req = 1;
    n = 0;
    for (int i = 0; i < 100 && n < 3; i++) begin
      step();
      if (app_wr_next_req) n++;
    end
    check("t6_beats_before_reset", 64'(n), 3);
    rst = 1; pend0 = 0; p0_req = 0;
    step();
    check("mid_rst_grant", 64'(arb_grant), 0);
    check("mid_rst_busy", 64'(arb_busy), 0);
    check("mid_rst_wr_en_n", 64'(app_wr_en_n), 64'hFF);
    check("mid_rst_wr_data", app_wr_data, 0);
    exp_q.delete();
    rst = 0;
    step();

    // T3: simultaneous held reads, expect grants 0,1,0,1
    p0_req_addr = 26'h000_1000; p0_req_len = 9'd2; p0_req_wr_n = 1'b1;
    p1_req_addr = 26'h3FF_F000; p1_req_len = 9'd3; p1_req_wr_n = 1'b1;
    push(1'b0); push(1'b1); push(1'b0); push(1'b1);
    pend0 = 2; pend1 = 2; p0_req = 1; p1_req = 1;
    run_done("t3", 300);

    // Mixed write traffic after alternation
    p1_req_addr = 26'h077_7770; p1_req_len = 9'd1; p1_req_wr_n = 1'b0;
    push(1'b1); pend1 = 1; p1_req = 1;
    run_done("t7", 100);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
